ahb3lite_sram_slave: RTL and testbench
======================================

Name: ahb3lite_sram_slave

Overview:
- Parametrised AHB3-Lite slave wrapping an on-chip word-addressed memory.
- Configurable data width, memory depth and programmable wait states.
- Supports byte, halfword and word lanes, plus the two-cycle ERROR response.
- Sits behind the AHB3-Lite decoder/mux as the standard memory target for bus-interface verification and subsystem integration.

Parameters:
- HADDR_SIZE, 32, address bus width.
- HDATA_SIZE, 32, data bus width; legal values 32 or 64.
- MEM_DEPTH, 256, number of HDATA_SIZE-bit words; power of two.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY data phase; range 0..15.

Ports:
- HCLK  input  1  bus clock; all logic on rising edge.
- HRESET  input  1  asynchronous, active-high reset.
- HSEL  input  1  slave select from decoder.
- HADDR  input  HADDR_SIZE  byte address.
- HWDATA  input  HDATA_SIZE  write data; valid in data phase.
- HRDATA  output  HDATA_SIZE  read data.
- HWRITE  input  1  1 = write, 0 = read.
- HSIZE  input  3  transfer size.
- HBURST  input  3  burst type; accepted, not used for addressing.
- HPROT  input  4  protection; ignored.
- HTRANS  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HREADY  input  1  bus-level ready from mux.
- HREADYOUT  output  1  slave ready.
- HRESP  output  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (async, HRESET=1):
  - HREADYOUT=1, HRESP=0, HRDATA=0, state=IDLE, wait counter=0.
  - Memory contents are not cleared.
  - Reset asserted mid data phase aborts it; no memory write commits.
- Address-phase accept: rising edge with HSEL=1, HREADY=1 and HTRANS[1]=1.
  - Registers HADDR, HWRITE and HSIZE.
  - Computes the error flag, then enters DATA, or ERR1 if the error flag is set.
- IDLE/BUSY transfers, or HSEL=0 with HREADY=1: no access; next cycle is OKAY with HREADYOUT=1.
- Error flag is set when either condition holds:
  - word index HADDR[HADDR_SIZE-1:log2(HDATA_SIZE/8)] >= MEM_DEPTH;
  - HSIZE > log2(HDATA_SIZE/8), i.e. wider than the bus.
- Unaligned addresses for the given HSIZE are not checked; low bits are masked to the size alignment.
- States:
  - IDLE: HREADYOUT=1, HRESP=0. On accept, go to DATA or ERR1.
  - DATA:
    - If the wait counter < WAIT_STATES: HREADYOUT=0, counter increments.
    - Else: HREADYOUT=1, HRESP=0, and the transfer completes this cycle.
    - On completion, a write commits HWDATA on the byte lanes selected by the registered HSIZE/HADDR low bits; the counter clears.
    - If a new accept occurs in the same completing cycle (pipelined), re-enter DATA or ERR1; otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1; always go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1; no memory access. A new accept in this cycle is honoured; otherwise go to IDLE.
- Write-strobe lanes:
  - byte: 1 lane, at addr[1:0], or addr[2:0] for 64-bit.
  - halfword: 2 lanes, aligned.
  - word: 4 lanes, aligned.
  - doubleword (64-bit bus only): all lanes.
- Read data:
  - In DATA, HRDATA = mem[registered word index] combinationally, full word, all lanes.
  - This gives read-after-write coherency for back-to-back transfers at zero wait states.
  - Outside DATA (IDLE, ERR1, ERR2), HRDATA=0.
- Latency: OKAY transfer data phase = 1+WAIT_STATES cycles; error = exactly 2 cycles.
- BUSY inserted in a burst while in DATA does not stall the current data phase.
- HREADY=0 from another slave: no accept; state holds.

Test Plan:
- Reset: HRESET=1 for 3 cycles with random inputs -> HREADYOUT=1, HRESP=0, HRDATA=0 every cycle; release, then IDLE transfer -> OKAY, zero wait.
- Word write/read, WAIT_STATES=0: NONSEQ write 0x10 <- 0xDEADBEEF, then NONSEQ read 0x10 back-to-back -> read data phase HRDATA=0xDEADBEEF, HREADYOUT=1 every cycle.
- Byte lanes: write word 0x20 <- 0x00000000, then byte write 0x22 with HWDATA=0x00AB0000 -> read 0x20 returns 0x00AB0000; halfword write 0x20 <- 0x00001234 -> read returns 0x00AB1234.
- Wait states, WAIT_STATES=3: single write then read -> each data phase shows exactly 3 cycles HREADYOUT=0, then 1 cycle HREADYOUT=1 with correct data.
- Errors, MEM_DEPTH=256, 32-bit: access 0x400 -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1), no write; HSIZE=3 to 0x0 -> same two-cycle ERROR.
- Mid-op reset, WAIT_STATES=2: write 0x30 <- 0x55AA55AA, assert HRESET in the 2nd wait cycle -> outputs return to reset values immediately; subsequent read of 0x30 returns the prior value, not 0x55AA55AA.

Source files
------------

// File: rtl/ahb3lite_sram_slave_if.sv
// AHB3-Lite bus bundle between a master/decoder side and a single memory slave.
// HREADY is the bus-level ready returned by the interconnect mux.
interface ahb3lite_sram_slave_if #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
);
  logic                  HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite slave around a word-addressed on-chip memory with byte-lane writes,
// programmable wait states and the two-cycle ERROR response.
module ahb3lite_sram_slave #(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input logic                HCLK,
  input logic                HRESET,
  ahb3lite_sram_slave_if.slave bus
);

  localparam int BYTES    = HDATA_SIZE / 8;
  localparam int ADDR_LSB = $clog2(BYTES);
  localparam int IDX_W    = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t                state, state_nxt;
  logic [3:0]            wait_cnt, wait_cnt_nxt;
  logic [IDX_W-1:0]      idx_q;
  logic [ADDR_LSB-1:0]   lane_q;
  logic                  write_q;
  logic [2:0]            size_q;

  logic                  accept;
  logic                  addr_err;
  logic                  load;
  logic                  ready;
  logic                  resp;
  logic                  mem_we;
  logic [BYTES-1:0]      strb;
  logic [HADDR_SIZE-1:0] word_idx;
  logic                  unused_bits;

  logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

  assign accept   = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign word_idx = bus.HADDR >> ADDR_LSB;
  assign addr_err = (word_idx >= HADDR_SIZE'(MEM_DEPTH)) || (bus.HSIZE > 3'(ADDR_LSB));

  assign unused_bits = ^{bus.HBURST, bus.HPROT, bus.HTRANS[0]};

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    ready        = 1'b1;
    resp         = 1'b0;
    load         = 1'b0;
    mem_we       = 1'b0;
    case (state)
      ST_IDLE: load = accept;
      ST_DATA: begin
        if (wait_cnt != 4'(WAIT_STATES)) begin
          ready        = 1'b0;
          wait_cnt_nxt = wait_cnt + 4'd1;
        end else begin
          wait_cnt_nxt = '0;
          mem_we       = write_q;
          load         = accept;
          state_nxt    = ST_IDLE;
        end
      end
      ST_ERR1: begin
        ready     = 1'b0;
        resp      = 1'b1;
        state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        resp      = 1'b1;
        load      = accept;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A pipelined accept overrides the return to IDLE.
    if (load) state_nxt = addr_err ? ST_ERR1 : ST_DATA;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      idx_q    <= '0;
      lane_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (load) begin
        idx_q   <= bus.HADDR[ADDR_LSB +: IDX_W];
        lane_q  <= bus.HADDR[ADDR_LSB-1:0];
        write_q <= bus.HWRITE;
        size_q  <= bus.HSIZE;
      end
    end
  end

  // A lane is written when it lies in the same size-aligned group as the address.
  always_comb begin
    strb = '0;
    for (int b = 0; b < BYTES; b++) begin
      strb[b] = ((ADDR_LSB'(b) >> size_q) == (lane_q >> size_q));
    end
  end

  // NOTE: the memory array has no reset; its contents survive HRESET and only
  // the control state above is cleared.
  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (strb[b]) mem[idx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
      end
    end
  end

  assign bus.HREADYOUT = ready;
  assign bus.HRESP     = resp;
  assign bus.HRDATA    = (state == ST_DATA) ? mem[idx_q] : '0;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Directed bench: three slaves (0, 3 and 2 wait states) share one stimulus bus;
// tgt selects which one sees HSEL and whose outputs are checked.
module tb_ahb3lite_sram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  size = '0;
  logic [1:0]  trans = '0;
  int          tgt = 0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ahb3lite_sram_slave_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus0 ();
  ahb3lite_sram_slave_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus3 ();
  ahb3lite_sram_slave_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus2 ();

  assign bus0.HSEL = sel && (tgt == 0);
  assign bus3.HSEL = sel && (tgt == 3);
  assign bus2.HSEL = sel && (tgt == 2);
  assign bus0.HADDR = addr;   assign bus3.HADDR = addr;   assign bus2.HADDR = addr;
  assign bus0.HWDATA = wdata; assign bus3.HWDATA = wdata; assign bus2.HWDATA = wdata;
  assign bus0.HWRITE = wr;    assign bus3.HWRITE = wr;    assign bus2.HWRITE = wr;
  assign bus0.HSIZE = size;   assign bus3.HSIZE = size;   assign bus2.HSIZE = size;
  assign bus0.HBURST = 3'd0;  assign bus3.HBURST = 3'd0;  assign bus2.HBURST = 3'd0;
  assign bus0.HPROT = 4'd3;   assign bus3.HPROT = 4'd3;   assign bus2.HPROT = 4'd3;
  assign bus0.HTRANS = trans; assign bus3.HTRANS = trans; assign bus2.HTRANS = trans;
  assign bus0.HREADY = bus0.HREADYOUT;
  assign bus3.HREADY = bus3.HREADYOUT;
  assign bus2.HREADY = bus2.HREADYOUT;

  ahb3lite_sram_slave #(.WAIT_STATES(0)) dut0 (.HCLK(clk), .HRESET(rst), .bus(bus0.slave));
  ahb3lite_sram_slave #(.WAIT_STATES(3)) dut3 (.HCLK(clk), .HRESET(rst), .bus(bus3.slave));
  ahb3lite_sram_slave #(.WAIT_STATES(2)) dut2 (.HCLK(clk), .HRESET(rst), .bus(bus2.slave));

  logic        rdy_m, resp_m;
  logic [31:0] rdata_m;
  assign rdy_m   = (tgt == 3) ? bus3.HREADYOUT : (tgt == 2) ? bus2.HREADYOUT : bus0.HREADYOUT;
  assign resp_m  = (tgt == 3) ? bus3.HRESP     : (tgt == 2) ? bus2.HRESP     : bus0.HRESP;
  assign rdata_m = (tgt == 3) ? bus3.HRDATA    : (tgt == 2) ? bus2.HRDATA    : bus0.HRDATA;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Single non-pipelined transfer; waits counts HREADYOUT-low data-phase cycles.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output int waits,
                      output logic first_resp, output logic last_resp);
    @(negedge clk);
    sel = 1'b1; trans = 2'd2; addr = a; wr = w; size = sz;
    @(negedge clk);
    sel = 1'b0; trans = 2'd0; wdata = wd;
    first_resp = resp_m;
    waits = 0;
    while (!rdy_m && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    rd = rdata_m;
    last_resp = resp_m;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          waits;
    logic        r0, r1;

    // Reset with random inputs: outputs stay at reset values.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sel = 1'($urandom); trans = 2'($urandom); addr = $urandom; wr = 1'($urandom);
      size = 3'($urandom); wdata = $urandom;
      #1;
      check("rst_ready", rdy_m, 1);
      check("rst_resp", resp_m, 0);
      check("rst_rdata", rdata_m, 0);
    end
    @(negedge clk);
    sel = 1'b0; trans = 2'd0; wr = 1'b0; size = 3'd2; rst = 1'b0;

    // IDLE transfer while selected: no access, OKAY with zero wait.
    @(negedge clk);
    sel = 1'b1; trans = 2'd0; addr = 32'h10;
    @(negedge clk);
    check("idle_ready", rdy_m, 1);
    check("idle_resp", resp_m, 0);
    sel = 1'b0;

    // Back-to-back write then read of 0x10.
    @(negedge clk);
    sel = 1'b1; trans = 2'd2; addr = 32'h10; wr = 1'b1; size = 3'd2;
    @(negedge clk);
    check("b2b_wr_ready", rdy_m, 1);
    wdata = 32'hDEADBEEF; wr = 1'b0;
    @(negedge clk);
    check("b2b_rd_ready", rdy_m, 1);
    check("b2b_rd_data", rdata_m, 32'hDEADBEEF);
    sel = 1'b0; trans = 2'd0;
    @(negedge clk);
    check("b2b_idle_rdata", rdata_m, 0);

    // Byte and halfword lanes.
    xfer(1'b1, 32'h20, 3'd2, 32'h0000_0000, rd, waits, r0, r1);
    xfer(1'b1, 32'h22, 3'd0, 32'h00AB_0000, rd, waits, r0, r1);
    xfer(1'b0, 32'h20, 3'd2, 32'h0, rd, waits, r0, r1);
    check("byte_rd", rd, 32'h00AB_0000);
    xfer(1'b1, 32'h20, 3'd1, 32'h0000_1234, rd, waits, r0, r1);
    xfer(1'b0, 32'h20, 3'd2, 32'h0, rd, waits, r0, r1);
    check("half_rd", rd, 32'h00AB_1234);
    xfer(1'b1, 32'h21, 3'd0, 32'hFFFF_FFFF, rd, waits, r0, r1);
    xfer(1'b0, 32'h20, 3'd2, 32'h0, rd, waits, r0, r1);
    check("byte1_mask_rd", rd, 32'h00AB_FF34);
    xfer(1'b1, 32'h23, 3'd1, 32'h5566_0000, rd, waits, r0, r1);
    xfer(1'b0, 32'h20, 3'd2, 32'h0, rd, waits, r0, r1);
    check("half_unaligned_rd", rd, 32'h5566_FF34);
    check("ws0_waits", waits, 0);

    // ERROR responses: out of range and oversized transfer; neither writes.
    xfer(1'b1, 32'h0, 3'd2, 32'h1111_1111, rd, waits, r0, r1);
    xfer(1'b1, 32'h400, 3'd2, 32'h9999_9999, rd, waits, r0, r1);
    check("err_range_waits", waits, 1);
    check("err_range_resp1", r0, 1);
    check("err_range_resp2", r1, 1);
    check("err_range_rdata", rd, 0);
    xfer(1'b1, 32'h0, 3'd3, 32'h2222_2222, rd, waits, r0, r1);
    check("err_size_waits", waits, 1);
    check("err_size_resp1", r0, 1);
    check("err_size_resp2", r1, 1);
    xfer(1'b0, 32'h0, 3'd2, 32'h0, rd, waits, r0, r1);
    check("err_nowrite_rd", rd, 32'h1111_1111);
    check("err_after_resp", r1, 0);

    // Three wait states.
    tgt = 3;
    xfer(1'b1, 32'h40, 3'd2, 32'hCAFE_F00D, rd, waits, r0, r1);
    check("ws3_wr_waits", waits, 3);
    check("ws3_wr_resp", r1, 0);
    xfer(1'b0, 32'h40, 3'd2, 32'h0, rd, waits, r0, r1);
    check("ws3_rd_waits", waits, 3);
    check("ws3_rd_data", rd, 32'hCAFE_F00D);

    // Reset in the second wait cycle of a write aborts it.
    tgt = 2;
    xfer(1'b1, 32'h30, 3'd2, 32'h0102_0304, rd, waits, r0, r1);
    check("ws2_wr_waits", waits, 2);
    @(negedge clk);
    sel = 1'b1; trans = 2'd2; addr = 32'h30; wr = 1'b1; size = 3'd2;
    @(negedge clk);
    check("mr_wait1", rdy_m, 0);
    sel = 1'b0; trans = 2'd0; wdata = 32'h55AA_55AA;
    @(negedge clk);
    check("mr_wait2", rdy_m, 0);
    rst = 1'b1;
    #1;
    check("mr_ready", rdy_m, 1);
    check("mr_resp", resp_m, 0);
    check("mr_rdata", rdata_m, 0);
    @(negedge clk);
    rst = 1'b0;
    xfer(1'b0, 32'h30, 3'd2, 32'h0, rd, waits, r0, r1);
    check("mr_rd_prior", rd, 32'h0102_0304);

    // Memory contents survive reset.
    tgt = 0;
    xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, waits, r0, r1);
    check("mem_kept", rd, 32'hDEADBEEF);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
